mem_port_arb: RTL and testbench

//  Shares the single data-memory port between the load unit and the store buffer's commit

---
 rtl/mem_port_arb.sv | 147 ++++++++++++++
 tb/tb_mem_port_arb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// ---------------------------------------------------------------------------
// mem_port_arb
//   Arbitrates the single data-memory port between the load unit and the
//   committed-store output of the store buffer. At most one read is
//   outstanding at a time. Once presented, a grant is held until the memory
//   accepts it. A saturating counter keeps stores from starving, and a store
//   to the same address as a pending load always goes first.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   ld_vld/ld_rdy/ld_id/ld_addr  load request channel
//   ld_rsp_vld/_id/_data         registered load response (1-cycle pulse)
//   st_vld/st_rdy/st_addr/st_data committed store channel
//   drain                        stores get absolute priority
//   mem_req_*                    memory request channel
//   mem_rsp_vld/mem_rsp_data     memory read response
// ---------------------------------------------------------------------------
module mem_port_arb #(
    parameter int INST_ID_BIT = 8,
    parameter int ADDR_BIT    = 16,
    parameter int DATA_BIT    = 16,
    parameter int STARVE_MAX  = 8,
    parameter int CNT_BIT     = $clog2(STARVE_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld_vld,
    output logic                   ld_rdy,
    input  logic [INST_ID_BIT-1:0] ld_id,
    input  logic [ADDR_BIT-1:0]    ld_addr,
    output logic                   ld_rsp_vld,
    output logic [INST_ID_BIT-1:0] ld_rsp_id,
    output logic [DATA_BIT-1:0]    ld_rsp_data,
    input  logic                   st_vld,
    output logic                   st_rdy,
    input  logic [ADDR_BIT-1:0]    st_addr,
    input  logic [DATA_BIT-1:0]    st_data,
    input  logic                   drain,
    output logic                   mem_req_vld,
    input  logic                   mem_req_rdy,
    output logic                   mem_req_we,
    output logic [ADDR_BIT-1:0]    mem_req_addr,
    output logic [DATA_BIT-1:0]    mem_req_data,
    input  logic                   mem_rsp_vld,
    input  logic [DATA_BIT-1:0]    mem_rsp_data
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] RD_WAIT = 1'b1;

    localparam logic [CNT_BIT-1:0] STARVE_LIM = CNT_BIT'(STARVE_MAX);

    logic [0:0]             state_reg;
    logic                   lock_reg;
    logic                   lock_st_reg;     // side held by the lock: 1 = store
    logic [CNT_BIT-1:0]     starve_cnt_reg;
    logic [INST_ID_BIT-1:0] ld_id_reg;
    logic                   ld_rsp_vld_reg;
    logic [INST_ID_BIT-1:0] ld_rsp_id_reg;
    logic [DATA_BIT-1:0]    ld_rsp_data_reg;

    logic grant_st;
    logic grant_ld;
    logic st_hs;
    logic ld_hs;

    // Grant selection. While locked the previously presented side is kept,
    // so a stalled request never changes under the memory's feet.
    always_comb begin
        grant_st = 1'b0;
        grant_ld = 1'b0;
        if (!rst && state_reg == IDLE) begin
            if (lock_reg) begin
                grant_st = lock_st_reg;
                grant_ld = !lock_st_reg;
            end else if (st_vld && (drain || !ld_vld ||
                                    starve_cnt_reg == STARVE_LIM ||
                                    st_addr == ld_addr)) begin
                grant_st = 1'b1;
            end else if (ld_vld) begin
                grant_ld = 1'b1;
            end
        end
    end

    assign mem_req_vld  = !rst && (state_reg == IDLE) && (st_vld || ld_vld);
    assign mem_req_we   = grant_st;
    assign mem_req_addr = grant_st ? st_addr : (grant_ld ? ld_addr : '0);
    assign mem_req_data = grant_st ? st_data : '0;

    assign st_hs  = grant_st && mem_req_rdy;
    assign ld_hs  = grant_ld && mem_req_rdy;
    assign st_rdy = st_hs;
    assign ld_rdy = ld_hs;

    assign ld_rsp_vld  = ld_rsp_vld_reg;
    assign ld_rsp_id   = ld_rsp_id_reg;
    assign ld_rsp_data = ld_rsp_data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            lock_reg        <= 1'b0;
            lock_st_reg     <= 1'b0;
            starve_cnt_reg  <= '0;
            ld_id_reg       <= '0;
            ld_rsp_vld_reg  <= 1'b0;
            ld_rsp_id_reg   <= '0;
            ld_rsp_data_reg <= '0;
        end else begin
            ld_rsp_vld_reg <= 1'b0;

            if (mem_req_vld && !mem_req_rdy) begin
                lock_reg    <= 1'b1;
                lock_st_reg <= grant_st;
            end else if (st_hs || ld_hs) begin
                lock_reg <= 1'b0;
            end

            // Counts every cycle a store waits, including RD_WAIT cycles.
            if (st_hs) begin
                starve_cnt_reg <= '0;
            end else if (st_vld && starve_cnt_reg != STARVE_LIM) begin
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (ld_hs) begin
                        state_reg <= RD_WAIT;
                        ld_id_reg <= ld_id;
                    end
                end
                RD_WAIT: begin
                    if (mem_rsp_vld) begin
                        state_reg       <= IDLE;
                        ld_rsp_vld_reg  <= 1'b1;
                        ld_rsp_id_reg   <= ld_id_reg;
                        ld_rsp_data_reg <= mem_rsp_data;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
module tb_mem_port_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_vld;
    logic        ld_rdy;
    logic [7:0]  ld_id;
    logic [15:0] ld_addr;
    logic        ld_rsp_vld;
    logic [7:0]  ld_rsp_id;
    logic [15:0] ld_rsp_data;
    logic        st_vld;
    logic        st_rdy;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic        drain;
    logic        mem_req_vld;
    logic        mem_req_rdy;
    logic        mem_req_we;
    logic [15:0] mem_req_addr;
    logic [15:0] mem_req_data;
    logic        mem_rsp_vld;
    logic [15:0] mem_rsp_data;

    int checks = 0;
    int fails  = 0;

    mem_port_arb dut (
        .clk(clk), .rst(rst),
        .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_id(ld_id), .ld_addr(ld_addr),
        .ld_rsp_vld(ld_rsp_vld), .ld_rsp_id(ld_rsp_id), .ld_rsp_data(ld_rsp_data),
        .st_vld(st_vld), .st_rdy(st_rdy), .st_addr(st_addr), .st_data(st_data),
        .drain(drain),
        .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_rsp_vld(mem_rsp_vld), .mem_rsp_data(mem_rsp_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ld_vld = 1'b1; ld_id = 8'h11; ld_addr = 16'h0001;
        st_vld = 1'b1; st_addr = 16'h0002; st_data = 16'h0003; drain = 1'b0;
        mem_req_rdy = 1'b1; mem_rsp_vld = 1'b0; mem_rsp_data = 16'h0;
        tick();
        checks++;
        if ({mem_req_vld, ld_rdy, st_rdy, mem_req_we, ld_rsp_vld} !== 5'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b required 00000",
                              {mem_req_vld, ld_rdy, st_rdy, mem_req_we, ld_rsp_vld});
        end
        checks++;
        if ({mem_req_addr, mem_req_data, ld_rsp_id, ld_rsp_data} !== 56'h0) begin
            fails++; $display("FAIL reset_data: got %h required 0",
                              {mem_req_addr, mem_req_data, ld_rsp_id, ld_rsp_data});
        end
        checks++;
        if (dut.state_reg !== 1'b0 || dut.starve_cnt_reg !== 4'd0 || dut.lock_reg !== 1'b0) begin
            fails++; $display("FAIL reset_state: got state=%b cnt=%0d lock=%b required 0 0 0",
                              dut.state_reg, dut.starve_cnt_reg, dut.lock_reg);
        end
        ld_vld = 1'b0; st_vld = 1'b0;
        rst = 1'b0;
        tick();
        $display("reset: done");
    endtask

    task automatic test_load_only();
        ld_vld = 1'b1; ld_id = 8'h5A; ld_addr = 16'h0010; mem_req_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req_vld, mem_req_we, ld_rdy, st_rdy} !== 4'b1010 || mem_req_addr !== 16'h0010
            || mem_req_data !== 16'h0) begin
            fails++; $display("FAIL load_issue: got vld/we/ldr/str=%b addr=%h data=%h required 1010 0010 0000",
                              {mem_req_vld, mem_req_we, ld_rdy, st_rdy}, mem_req_addr, mem_req_data);
        end
        tick();
        ld_id = 8'h77; ld_addr = 16'h0099;   // still requesting, must be ignored
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (ld_rdy !== 1'b0 || mem_req_vld !== 1'b0 || ld_rsp_vld !== 1'b0) begin
                fails++; $display("FAIL load_rdwait%0d: got ldr=%b vld=%b rsp=%b required 0 0 0",
                                  i, ld_rdy, mem_req_vld, ld_rsp_vld);
            end
            tick();
        end
        ld_vld = 1'b0;
        mem_rsp_vld = 1'b1; mem_rsp_data = 16'hBEEF;
        tick();
        mem_rsp_vld = 1'b0; mem_rsp_data = 16'h0;
        checks++;
        if (ld_rsp_vld !== 1'b1 || ld_rsp_id !== 8'h5A || ld_rsp_data !== 16'hBEEF) begin
            fails++; $display("FAIL load_rsp: got vld=%b id=%h data=%h required 1 5a beef",
                              ld_rsp_vld, ld_rsp_id, ld_rsp_data);
        end
        tick();
        checks++;
        if (ld_rsp_vld !== 1'b0) begin
            fails++; $display("FAIL load_rsp_pulse: got %b required 0", ld_rsp_vld);
        end
        $display("load_only: id=5a data=beef");
    endtask

    task automatic test_store_burst();
        logic [15:0] a, d;
        st_vld = 1'b1; mem_req_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 16'h0020 + 16'(i); d = 16'h1000 + 16'(i);
            st_addr = a; st_data = d;
            @(negedge clk);
            checks++;
            if (st_rdy !== 1'b1 || mem_req_we !== 1'b1 || mem_req_addr !== a || mem_req_data !== d) begin
                fails++; $display("FAIL store_burst%0d: got rdy=%b we=%b addr=%h data=%h required 1 1 %h %h",
                                  i, st_rdy, mem_req_we, mem_req_addr, mem_req_data, a, d);
            end
            tick();
            $display("store_burst: beat %0d addr=%h data=%h", i, a, d);
        end
        st_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (st_rdy !== 1'b0 || mem_req_vld !== 1'b0) begin
            fails++; $display("FAIL store_idle: got rdy=%b vld=%b required 0 0", st_rdy, mem_req_vld);
        end
        tick();
    endtask

    // Loads accepted on even cycles, responses on odd cycles; the waiting
    // store's counter reaches 8 at cycle 8, where the store is forced.
    task automatic test_starvation();
        st_vld = 1'b1; st_addr = 16'h0200; st_data = 16'h5555;
        ld_vld = 1'b1; mem_req_rdy = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            ld_addr = 16'h0100 + 16'(c); ld_id = 8'(c);
            mem_rsp_vld = c[0]; mem_rsp_data = 16'h00A0 + 16'(c);
            @(negedge clk);
            checks++;
            if (c == 8) begin
                if (st_rdy !== 1'b1 || mem_req_we !== 1'b1 || ld_rdy !== 1'b0 || dut.starve_cnt_reg !== 4'd8) begin
                    fails++; $display("FAIL starve_force: got str=%b we=%b ldr=%b cnt=%0d required 1 1 0 8",
                                      st_rdy, mem_req_we, ld_rdy, dut.starve_cnt_reg);
                end
            end else if (c[0] == 1'b0) begin
                if (ld_rdy !== 1'b1 || st_rdy !== 1'b0 || mem_req_we !== 1'b0) begin
                    fails++; $display("FAIL starve_load%0d: got ldr=%b str=%b we=%b required 1 0 0",
                                      c, ld_rdy, st_rdy, mem_req_we);
                end
            end else begin
                if (mem_req_vld !== 1'b0 || st_rdy !== 1'b0) begin
                    fails++; $display("FAIL starve_wait%0d: got vld=%b str=%b required 0 0",
                                      c, mem_req_vld, st_rdy);
                end
            end
            tick();
        end
        mem_rsp_vld = 1'b0; st_vld = 1'b0; ld_vld = 1'b0;
        checks++;
        if (dut.starve_cnt_reg !== 4'd0) begin
            fails++; $display("FAIL starve_clear: got cnt=%0d required 0", dut.starve_cnt_reg);
        end
        $display("starvation: store forced after 4 loads");
    endtask

    task automatic test_hazard();
        ld_vld = 1'b1; ld_id = 8'h33; ld_addr = 16'h0040;
        st_vld = 1'b1; st_addr = 16'h0040; st_data = 16'hCAFE; mem_req_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (st_rdy !== 1'b1 || ld_rdy !== 1'b0 || mem_req_we !== 1'b1 || mem_req_data !== 16'hCAFE) begin
            fails++; $display("FAIL hazard_store: got str=%b ldr=%b we=%b data=%h required 1 0 1 cafe",
                              st_rdy, ld_rdy, mem_req_we, mem_req_data);
        end
        tick();
        st_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (ld_rdy !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 16'h0040) begin
            fails++; $display("FAIL hazard_load: got ldr=%b we=%b addr=%h required 1 0 0040",
                              ld_rdy, mem_req_we, mem_req_addr);
        end
        tick();
        ld_vld = 1'b0;
        mem_rsp_vld = 1'b1; mem_rsp_data = 16'hCAFE;
        tick();
        mem_rsp_vld = 1'b0;
        checks++;
        if (ld_rsp_vld !== 1'b1 || ld_rsp_id !== 8'h33 || ld_rsp_data !== 16'hCAFE) begin
            fails++; $display("FAIL hazard_rsp: got vld=%b id=%h data=%h required 1 33 cafe",
                              ld_rsp_vld, ld_rsp_id, ld_rsp_data);
        end
        $display("hazard: store then load, data=cafe");
    endtask

    task automatic test_lock();
        ld_vld = 1'b1; ld_id = 8'h44; ld_addr = 16'h0050; mem_req_rdy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                st_vld = 1'b1; st_addr = 16'h0060; st_data = 16'h6666; drain = 1'b1;
            end
            if (c == 3) mem_req_rdy = 1'b1;
            @(negedge clk);
            checks++;
            if (mem_req_vld !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 16'h0050
                || st_rdy !== 1'b0 || ld_rdy !== (c == 3)) begin
                fails++; $display("FAIL lock_c%0d: got vld=%b we=%b addr=%h str=%b ldr=%b required 1 0 0050 0 %b",
                                  c, mem_req_vld, mem_req_we, mem_req_addr, st_rdy, ld_rdy, c == 3);
            end
            tick();
        end
        ld_vld = 1'b0; drain = 1'b0;
        mem_rsp_vld = 1'b1; mem_rsp_data = 16'h4444;
        @(negedge clk);
        checks++;
        if (st_rdy !== 1'b0) begin
            fails++; $display("FAIL lock_rdwait: got str=%b required 0", st_rdy);
        end
        tick();
        mem_rsp_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (st_rdy !== 1'b1 || ld_rsp_vld !== 1'b1 || ld_rsp_data !== 16'h4444) begin
            fails++; $display("FAIL lock_after: got str=%b rsp=%b data=%h required 1 1 4444",
                              st_rdy, ld_rsp_vld, ld_rsp_data);
        end
        tick();
        st_vld = 1'b0;
        $display("lock: load held 3 cycles then accepted");
    endtask

    task automatic test_reset_rdwait();
        ld_vld = 1'b1; ld_id = 8'h66; ld_addr = 16'h0070; mem_req_rdy = 1'b1;
        tick();
        checks++;
        if (dut.state_reg !== 1'b1) begin
            fails++; $display("FAIL rst_rd_enter: got state=%b required 1", dut.state_reg);
        end
        st_vld = 1'b1; st_addr = 16'h0080; st_data = 16'h8888;
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_req_vld, ld_rdy, st_rdy, mem_req_we, ld_rsp_vld} !== 5'b0
            || {mem_req_addr, mem_req_data} !== 32'h0 || dut.state_reg !== 1'b0) begin
            fails++; $display("FAIL rst_rd_outs: got ctl=%b addr=%h data=%h state=%b required 0",
                              {mem_req_vld, ld_rdy, st_rdy, mem_req_we, ld_rsp_vld},
                              mem_req_addr, mem_req_data, dut.state_reg);
        end
        tick();
        ld_vld = 1'b0; st_vld = 1'b0;
        rst = 1'b0;
        mem_rsp_vld = 1'b1; mem_rsp_data = 16'hDEAD;
        tick();
        mem_rsp_vld = 1'b0;
        checks++;
        if (ld_rsp_vld !== 1'b0) begin
            fails++; $display("FAIL rst_rd_late: got rsp=%b required 0", ld_rsp_vld);
        end
        tick();
        checks++;
        if (ld_rsp_vld !== 1'b0 || dut.state_reg !== 1'b0) begin
            fails++; $display("FAIL rst_rd_after: got rsp=%b state=%b required 0 0",
                              ld_rsp_vld, dut.state_reg);
        end
        $display("reset_rdwait: late response dropped");
    endtask

    initial begin
        test_reset();
        test_load_only();
        test_store_burst();
        test_starvation();
        test_hazard();
        test_lock();
        test_reset_rdwait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
